// File: rtl/cacheline_burst_responder.sv
// Memory-side responder for the cache's 256-bit downward port. Takes one line
// read or write at a time and moves it over a 64-bit burst bus, BEATS beats
// per line, then pulses dfp_resp for one cycle.
module cacheline_burst_responder #(
  parameter int BEAT_WIDTH  = 64,
  parameter int BEATS       = 4,
  parameter int LINE_WIDTH  = 256,
  parameter int OFFSET_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_resp,
  output logic [31:0]           bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // A line must split into a whole number of beats with no leftover bits.
  if (LINE_WIDTH != BEAT_WIDTH * BEATS) begin : g_bad_geometry
    $error("LINE_WIDTH must equal BEAT_WIDTH*BEATS");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR_BURST,
    RD_CMD,
    RD_BURST,
    RESP
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [LINE_WIDTH-1:0] wline_q;      // line being written, latched at accept
  logic [LINE_WIDTH-1:0] rline_q;      // read beats collected so far
  logic [LINE_WIDTH-1:0] rline_d;
  logic [LINE_WIDTH-1:0] dfp_rdata_q;
  logic                  dfp_resp_q;
  logic [31:0]           bmem_addr_q;
  logic                  bmem_read_q;
  logic                  bmem_write_q;
  logic [BEAT_WIDTH-1:0] bmem_wdata_q;

  logic [31:0]           line_addr;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  unused_offset_bits;

  // Bursts always start on a line boundary; the offset bits are dropped.
  assign line_addr          = {dfp_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign unused_offset_bits = ^dfp_addr[OFFSET_BITS-1:0];
  assign cnt_inc            = cnt_q + CNT_W'(1);

  // Read line with the incoming beat merged into the current slot.
  always_comb begin
    // NOTE: assign a full default before the partial update so no latch is inferred.
    rline_d = rline_q;
    rline_d[BEAT_WIDTH*cnt_q +: BEAT_WIDTH] = bmem_rdata;
  end

  // Transaction FSM with all bus-facing outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      // NOTE: the line buffers are ordinary flops, so clearing them on reset is cheap and keeps aborted data from lingering.
      wline_q      <= '0;
      rline_q      <= '0;
      dfp_rdata_q  <= '0;
      dfp_resp_q   <= 1'b0;
      bmem_addr_q  <= '0;
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
      bmem_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every branch sees the pre-edge state.
      dfp_resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A write wins over a simultaneous read; a held read is taken later.
          if (dfp_write) begin
            bmem_addr_q  <= line_addr;
            wline_q      <= dfp_wdata;
            bmem_wdata_q <= dfp_wdata[BEAT_WIDTH-1:0];
            bmem_write_q <= 1'b1;
            cnt_q        <= '0;
            state_q      <= WR_BURST;
          end else if (dfp_read) begin
            bmem_addr_q  <= line_addr;
            bmem_read_q  <= 1'b1;
            cnt_q        <= '0;
            state_q      <= RD_CMD;
          end
        end
        WR_BURST: begin
          if (bmem_ready) begin
            if (cnt_q == LAST_BEAT) begin
              bmem_write_q <= 1'b0;
              cnt_q        <= '0;
              dfp_resp_q   <= 1'b1;
              state_q      <= RESP;
            end else begin
              bmem_wdata_q <= wline_q[BEAT_WIDTH*cnt_inc +: BEAT_WIDTH];
              cnt_q        <= cnt_inc;
            end
          end
        end
        RD_CMD: begin
          if (bmem_ready) begin
            bmem_read_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (bmem_rvalid) begin
            rline_q <= rline_d;
            if (cnt_q == LAST_BEAT) begin
              dfp_rdata_q <= rline_d;
              cnt_q       <= '0;
              dfp_resp_q  <= 1'b1;
              state_q     <= RESP;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        RESP: begin
          // Requests are not sampled here so a held request is not serviced twice.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dfp_rdata  = dfp_rdata_q;
  assign dfp_resp   = dfp_resp_q;
  assign bmem_addr  = bmem_addr_q;
  assign bmem_read  = bmem_read_q;
  assign bmem_write = bmem_write_q;
  assign bmem_wdata = bmem_wdata_q;

endmodule

// File: tb/tb_cacheline_burst_responder.sv
// Self-checking bench for cacheline_burst_responder: a memory model answers
// the burst bus and a transaction-level model predicts every line and beat.
module tb_cacheline_burst_responder;

  localparam int BW    = 64;
  localparam int BEATS = 4;
  localparam int LW    = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   dfp_addr;
  logic          dfp_read;
  logic          dfp_write;
  logic [LW-1:0] dfp_wdata;
  logic [LW-1:0] dfp_rdata;
  logic          dfp_resp;
  logic [31:0]   bmem_addr;
  logic          bmem_read;
  logic          bmem_write;
  logic [BW-1:0] bmem_wdata;
  logic          bmem_ready;
  logic [BW-1:0] bmem_rdata;
  logic          bmem_rvalid;

  int n_cmp = 0;
  int n_bad = 0;
  logic [LW-1:0] last_rdata;   // what dfp_rdata must show between reads

  always #5 clk = ~clk;

  cacheline_burst_responder dut (
    .clk        (clk),
    .rst        (rst),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [BW-1:0] rand_beat();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & 32'hFFFF_FFE0;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_resp"},  dfp_resp,   0);
    check({tag, "_rdata"}, dfp_rdata,  0);
    check({tag, "_rd"},    bmem_read,  0);
    check({tag, "_wr"},    bmem_write, 0);
    check({tag, "_addr"},  bmem_addr,  0);
    check({tag, "_wdata"}, bmem_wdata, 0);
  endtask

  // rmode: 0 always ready, 1 random ready, 2 ready low on burst cycles 2-3.
  task automatic do_write(input logic [31:0] addr, input logic [LW-1:0] data,
                          input int rmode, input bit with_read, output int lat);
    int k = 0;
    int c = 0;
    int cyc = 0;
    bit done = 0;
    bit rdy;
    lat = -1;
    dfp_addr = addr; dfp_wdata = data; dfp_write = 1'b1; dfp_read = with_read;
    bmem_rvalid = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        dfp_addr  = $urandom;
        dfp_wdata = rand_line();
      end
      if (dfp_resp) begin
        check("wr_beats", k, BEATS);
        check("wr_valid_drop", bmem_write, 0);
        check("wr_rdata_hold", dfp_rdata, last_rdata);
        lat = cyc;
        dfp_write = 1'b0;
        done = 1;
      end else if (cyc > 200) begin
        check("wr_timeout", dfp_resp, 1);
        dfp_write = 1'b0;
        done = 1;
      end else begin
        check("wr_valid", bmem_write, 1);
        check("wr_no_read", bmem_read, 0);
        check("wr_addr", bmem_addr, line_of(addr));
        if (k < BEATS) check("wr_beat", bmem_wdata, data[BW*k +: BW]);
        case (rmode)
          0:       rdy = 1'b1;
          1:       rdy = ($urandom % 4) != 0;
          default: rdy = !(c == 1 || c == 2);
        endcase
        c++;
        bmem_ready = rdy;
        if (rdy) k++;
      end
    end
    bmem_ready = $urandom;
    @(negedge clk);
    check("wr_resp_once", dfp_resp, 0);
    check("wr_idle_rd", bmem_read, 0);
    check("wr_idle_wr", bmem_write, 0);
  endtask

  // vmode: 0 rvalid always, 1 random gaps, 2 two-cycle gap after beat 1.
  // abort_at >= 0 pulses rst once that many beats have been returned.
  task automatic do_read(input logic [31:0] addr, input int vmode, input int rmode,
                         input bit directed, input logic [LW-1:0] given,
                         input bit hold, input int abort_at, output int lat);
    int k = 0;
    int cyc = 0;
    int gap = 0;
    bit cmd_done = 0;
    bit done = 0;
    bit rdy;
    bit v;
    logic [LW-1:0] exp_line = '0;
    logic [BW-1:0] beat;
    lat = -1;
    dfp_addr = addr; dfp_read = 1'b1; dfp_write = 1'b0; bmem_rvalid = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) dfp_addr = $urandom;
      if (abort_at >= 0 && k == abort_at && cmd_done) begin
        check("abort_no_resp", dfp_resp, 0);
        rst = 1'b1; dfp_read = 1'b0; bmem_rvalid = 1'b0; bmem_ready = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        rst = 1'b0;
        last_rdata = '0;
        return;
      end
      if (dfp_resp) begin
        check("rd_beats", k, BEATS);
        check("rd_line", dfp_rdata, exp_line);
        check("rd_cmd_drop", bmem_read, 0);
        last_rdata = exp_line;
        lat = cyc;
        if (!hold) dfp_read = 1'b0;
        done = 1;
      end else if (cyc > 200) begin
        check("rd_timeout", dfp_resp, 1);
        dfp_read = 1'b0;
        done = 1;
      end else if (!cmd_done) begin
        check("rd_cmd", bmem_read, 1);
        check("rd_addr", bmem_addr, line_of(addr));
        check("rd_no_write", bmem_write, 0);
        rdy = (rmode == 0) ? 1'b1 : (($urandom % 3) != 0);
        bmem_ready  = rdy;
        bmem_rvalid = $urandom;   // not yet bursting: must be ignored
        bmem_rdata  = rand_beat();
        if (rdy) cmd_done = 1;
      end else begin
        check("rd_cmd_off", bmem_read, 0);
        bmem_ready = $urandom;
        case (vmode)
          0: v = 1'b1;
          1: v = ($urandom % 3) != 0;
          default: begin
            if (k == 2 && gap < 2) begin
              v = 1'b0;
              gap++;
            end else begin
              v = 1'b1;
            end
          end
        endcase
        if (k >= BEATS) v = 1'b0;
        if (v) begin
          beat = directed ? given[BW*k +: BW] : rand_beat();
          exp_line[BW*k +: BW] = beat;
          k++;
          bmem_rdata = beat;
        end else begin
          bmem_rdata = rand_beat();
        end
        bmem_rvalid = v;
      end
    end
    // Completion cycle: a stray rvalid must not disturb the finished line.
    bmem_rvalid = 1'b1;
    bmem_rdata  = rand_beat();
    @(negedge clk);
    bmem_rvalid = 1'b0;
    check("rd_resp_once", dfp_resp, 0);
    check("rd_idle_rd", bmem_read, 0);
    check("rd_rdata_hold", dfp_rdata, last_rdata);
  endtask

  initial begin
    int lat;
    logic [LW-1:0] line;
    rst = 1'b1; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    last_rdata = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Plain write, memory always ready.
    line = {64'hD, 64'hC, 64'hB, 64'hA};
    do_write(32'h0000_1234, line, 0, 0, lat);
    check("wr_latency", lat, 5);

    // Write with ready low on burst cycles 2-3.
    do_write(32'h0000_1234, rand_line(), 2, 0, lat);
    check("wr_bp_latency", lat, 7);

    // Read with all beats back-to-back.
    do_read(32'h0000_0500, 0, 0, 0, '0, 0, -1, lat);
    check("rd_latency", lat, 6);

    // Read with a two-cycle rvalid gap after 0x22.
    line = {64'h44, 64'h33, 64'h22, 64'h11};
    do_read(32'h8000_0040, 2, 0, 1, line, 0, -1, lat);
    check("rd_gap_latency", lat, 8);

    // A write must leave dfp_rdata alone.
    do_write(32'h0000_2000, rand_line(), 1, 0, lat);

    // Held read request: one extra idle cycle, then exactly one more read.
    do_read(32'h0000_3000, 1, 1, 0, '0, 1, -1, lat);
    do_read(32'h0000_3040, 1, 1, 0, '0, 0, -1, lat);

    // Simultaneous read and write: write first, then the still-held read.
    do_write(32'h0000_0100, rand_line(), 0, 1, lat);
    do_read(32'h0000_0100, 0, 0, 0, '0, 0, -1, lat);

    // Reset in the middle of a read burst, then a normal write.
    do_read(32'h0000_4000, 0, 0, 0, '0, 0, 2, lat);
    do_write(32'h0000_5000, rand_line(), 0, 0, lat);
    check("post_abort_latency", lat, 5);

    // Randomised mix.
    for (int i = 0; i < 40; i++) begin
      case ($urandom % 3)
        0: do_write($urandom, rand_line(), 1, 0, lat);
        1: do_read($urandom, 1, 1, 0, '0, ($urandom % 4) == 0, -1, lat);
        default: begin
          do_write($urandom, rand_line(), 1, 1, lat);
          do_read($urandom, 1, 1, 0, '0, 0, -1, lat);
        end
      endcase
      // A held read from above is still asserted; finish it before idling.
      if (dfp_read) do_read($urandom, 1, 1, 0, '0, 0, -1, lat);
      repeat ($urandom % 3) begin
        @(negedge clk);
        check("idle_resp", dfp_resp, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
